// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - observed-counter bus between a counter bench and its checker
interface counter_checker_if #(
    parameter int WIDTH  = 8,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic [WIDTH-1:0]  value;
    logic              valid;
    logic              clear;
    logic              locked;
    logic              mismatch;
    logic              restart;
    logic [WIDTH-1:0]  expected;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;

    modport master (
        output value, valid, clear,
        input  locked, mismatch, restart, expected, err_count, wrap_count
    );

    modport slave (
        input  value, valid, clear,
        output locked, mismatch, restart, expected, err_count, wrap_count
    );
endinterface

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - lock/mismatch/restart/wrap monitor for a free-running counter
module counter_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 2,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    counter_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [4:0]       LOCK_TGT = 5'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t            state, state_nx;
    logic [3:0]        run, run_nx;
    logic [WIDTH-1:0]  exp_q, exp_nx;
    logic              mis_q, mis_nx;
    logic              rs_q, rs_nx;
    logic [ERR_W-1:0]  err_q, err_nx;
    logic [WRAP_W-1:0] wrap_q, wrap_nx;
    logic              err_inc, wrap_inc;

    logic [WIDTH-1:0]  value_inc;
    logic [4:0]        run_inc;

    assign value_inc = bus.value + ONE;
    assign run_inc   = {1'b0, run} + 5'd1;

    // State and counter registers; reset returns everything to IDLE/zero at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            run    <= 4'd0;
            exp_q  <= ZERO;
            mis_q  <= 1'b0;
            rs_q   <= 1'b0;
            err_q  <= '0;
            wrap_q <= '0;
        end else begin
            state  <= state_nx;
            run    <= run_nx;
            exp_q  <= exp_nx;
            mis_q  <= mis_nx;
            rs_q   <= rs_nx;
            err_q  <= err_nx;
            wrap_q <= wrap_nx;
        end
    end

    // Prediction FSM: classify each valid sample and pick next state/prediction
    always_comb begin
        state_nx = state;
        run_nx   = run;
        exp_nx   = exp_q;
        mis_nx   = 1'b0;
        rs_nx    = 1'b0;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;
        if (bus.valid) begin
            case (state)
                IDLE: begin
                    exp_nx   = value_inc;
                    run_nx   = 4'd0;
                    state_nx = ACQUIRE;
                end
                ACQUIRE: begin
                    exp_nx = value_inc;
                    if (bus.value == exp_q) begin
                        run_nx = run_inc[3:0];
                        if (run_inc == LOCK_TGT) state_nx = LOCKED;
                    end else begin
                        run_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (bus.value == exp_q) begin
                        exp_nx = value_inc;
                        // a correct sample of zero means the counter rolled over
                        if (bus.value == ZERO) wrap_inc = 1'b1;
                    end else if (bus.value == ZERO) begin
                        // counter was reset by its owner: legal, resync on 1
                        rs_nx  = 1'b1;
                        exp_nx = ONE;
                    end else begin
                        mis_nx   = 1'b1;
                        err_inc  = 1'b1;
                        exp_nx   = value_inc;
                        run_nx   = 4'd0;
                        state_nx = ACQUIRE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_comb begin
        err_nx  = err_q;
        wrap_nx = wrap_q;
        if (bus.clear) begin
            err_nx  = '0;
            wrap_nx = '0;
        end else begin
            if (err_inc && err_q != ERR_MAX)    err_nx  = err_q + ERR_W'(1);
            if (wrap_inc && wrap_q != WRAP_MAX) wrap_nx = wrap_q + WRAP_W'(1);
        end
    end

    assign bus.locked     = (state == LOCKED);
    assign bus.mismatch   = mis_q;
    assign bus.restart    = rs_q;
    assign bus.expected   = exp_q;
    assign bus.err_count  = err_q;
    assign bus.wrap_count = wrap_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - directed vector bench for counter_checker
module tb_counter_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    counter_checker_if #(.WIDTH(8), .ERR_W(8), .WRAP_W(16)) cif ();

    counter_checker #(.WIDTH(8), .LOCK_LEN(2), .ERR_W(8), .WRAP_W(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (cif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  val;
        logic        clr;
        logic        lk;
        logic        mis;
        logic        rs;
        logic [7:0]  ex;
        logic [7:0]  err;
        logic [15:0] wrap;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [7:0] val, input logic clr);
        @(negedge clk);
        cif.valid = vld;
        cif.value = val;
        cif.clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic lk, input logic mis, input logic rs,
                           input logic [7:0] ex, input logic [7:0] err, input logic [15:0] wrap);
        chk({tag, "_locked"},   32'(cif.locked),     32'(lk));
        chk({tag, "_mismatch"}, 32'(cif.mismatch),   32'(mis));
        chk({tag, "_restart"},  32'(cif.restart),    32'(rs));
        chk({tag, "_expected"}, 32'(cif.expected),   32'(ex));
        chk({tag, "_err"},      32'(cif.err_count),  32'(err));
        chk({tag, "_wrap"},     32'(cif.wrap_count), 32'(wrap));
    endtask

    logic [7:0] cur;
    logic [7:0] m;

    initial begin
        //            vld   val    clr   lk    mis   rs    ex     err    wrap
        vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 16'd0};
        vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 16'd0};
        vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 16'd0};
        vecs[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 16'd0};
        vecs[4]  = '{1'b0, 8'h4D, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 16'd0};
        vecs[5]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 16'd0};
        vecs[6]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00, 16'd0};
        vecs[7]  = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 8'h07, 8'h00, 16'd0};
        vecs[8]  = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 8'h01, 16'd0};
        vecs[9]  = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 8'h01, 16'd0};
        vecs[10] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0B, 8'h01, 16'd0};
        vecs[11] = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0C, 8'h01, 16'd0};
        vecs[12] = '{1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D, 8'h01, 16'd0};
        vecs[13] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 16'd0};
        vecs[14] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 16'd0};
        vecs[15] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h01, 16'd0};
        vecs[16] = '{1'b1, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFD, 8'h02, 16'd0};
        vecs[17] = '{1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h02, 16'd0};
        vecs[18] = '{1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h02, 16'd0};
        vecs[19] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 16'd0};
        vecs[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h02, 16'd1};
        vecs[21] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 16'd1};
        vecs[22] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 8'h00, 16'd0};
        vecs[23] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 16'd0};

        cif.valid = 1'b0;
        cif.value = 8'h00;
        cif.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].vld, vecs[i].val, vecs[i].clr);
            chk_all($sformatf("v%0d", i), vecs[i].lk, vecs[i].mis, vecs[i].rs,
                    vecs[i].ex, vecs[i].err, vecs[i].wrap);
        end

        // asynchronous reset between edges while locked
        step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h05, 1'b0);
        chk("pre_reset_locked", 32'(cif.locked), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h32, 1'b0);
        chk_all("reacq0", 1'b0, 1'b0, 1'b0, 8'h33, 8'h00, 16'd0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h34, 1'b0);
        chk_all("reacq2", 1'b1, 1'b0, 1'b0, 8'h35, 8'h00, 16'd0);

        // 260 mismatches, each followed by a two-sample relock
        cur = 8'h35;
        for (int k = 0; k < 260; k++) begin
            m = cur + 8'd7;
            if (m == 8'h00) m = 8'h03;
            step(1'b1, m, 1'b0);
            chk($sformatf("sat%0d_mismatch", k), 32'(cif.mismatch), 32'd1);
            if (k == 254) chk("sat_at_255", 32'(cif.err_count), 32'hFF);
            step(1'b1, m + 8'd1, 1'b0);
            step(1'b1, m + 8'd2, 1'b0);
            cur = m + 8'd3;
        end
        chk("sat_err", 32'(cif.err_count), 32'hFF);
        chk("sat_locked", 32'(cif.locked), 32'd1);

        // clear beats a simultaneous mismatch increment
        m = cur + 8'd7;
        if (m == 8'h00) m = 8'h03;
        step(1'b1, m, 1'b1);
        chk_all("clear_mis", 1'b0, 1'b1, 1'b0, m + 8'd1, 8'h00, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_checker.md
# counter_checker

Self-checking monitor for the 8-bit free-running counter: samples the counter's `value` bus every qualified clock, predicts the next value (+1 modulo 2^WIDTH), and reports lock status, mismatches, counter restarts and wrap-arounds. It sits beside the counter instance in simulation benches and in debug builds, and replaces manual inspection of the `$monitor` log.

## Interface
Parameters:
- WIDTH, 8, width of the observed counter value
- LOCK_LEN, 2, consecutive correct increments required to declare lock (1..15)
- ERR_W, 8, width of the saturating error counter
- WRAP_W, 16, width of the saturating wrap counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- value  in  WIDTH  observed counter output
- valid  in  1  value is meaningful this cycle; when low, checker holds all state
- clear  in  1  synchronous clear of err_count and wrap_count only
- locked  out  1  high while in LOCKED state
- mismatch  out  1  one-cycle pulse: unexpected value while LOCKED
- restart  out  1  one-cycle pulse: legal counter restart (value 0 mid-count) while LOCKED
- expected  out  WIDTH  predicted next value
- err_count  out  ERR_W  number of mismatches, saturating at all-ones
- wrap_count  out  WRAP_W  number of max→0 wraps seen while LOCKED, saturating

## Operation
- States: IDLE, ACQUIRE, LOCKED. Internal match counter `run` (4 bits).
- Every transition requires valid=1; valid=0 holds state, expected, counters; pulses drop to 0.
- IDLE: on valid, expected←value+1, run←0, go ACQUIRE.
- ACQUIRE: on valid and value==expected: expected←value+1, run←run+1; when run+1==LOCK_LEN go LOCKED. On valid and value≠expected: expected←value+1, run←0, stay ACQUIRE. No error counting in ACQUIRE.
- LOCKED, on valid:
  - value==expected: expected←value+1; if value==0 (wrap), wrap_count+1 (saturating).
  - value≠expected and value==0: restart pulse, expected←1, stay LOCKED, no error.
  - otherwise: mismatch pulse, err_count+1 (saturating), expected←value+1, run←0, go ACQUIRE.
- Arithmetic: expected = (value+1) mod 2^WIDTH; 8'hFF predicts 8'h00.
- clear: err_count and wrap_count←0 next edge; clear has priority over a same-cycle increment (result is 0). FSM, expected, pulses unaffected.
- Saturation: counters stick at all-ones; further events still pulse mismatch/restart.

## Timing
- Reset (reset=0): state IDLE, run=0, expected=0, locked=0, mismatch=0, restart=0, err_count=0, wrap_count=0; asynchronous assert, outputs valid immediately; released synchronously to clock by the bench/top.
- Reset mid-operation: all of the above regardless of state; first valid after release behaves as IDLE.
- All outputs registered; value sampled at edge N is reflected in outputs after edge N (1-cycle latency from the sampled cycle).
- mismatch and restart are exactly one cycle wide per offending sample; never both high.
- locked asserts on the edge that samples the LOCK_LEN-th consecutive match after the first capture: with continuous valid and a correct counter, locked rises at the (LOCK_LEN+1)-th sampled edge.
- locked deasserts on the same edge that raises mismatch.

## Test plan
- Clean count: reset released, valid=1, value 0,1,2,… → locked=1 after 3rd sample (LOCK_LEN=2), err_count=0, expected always value+1.
- Wrap: locked, value …8'hFE,8'hFF,8'h00,8'h01 → wrap_count=1, no mismatch, expected=8'h02 after 8'h01.
- Counter reset: locked, value 8'h28 then 8'h00 then 8'h01 → restart pulses once, locked stays 1, err_count=0.
- Glitch: locked, value 5,6,9,10,11 → mismatch pulse on 9, err_count=1, locked=0 then relocks after 10,11; valid=0 cycles in between hold everything.
- Saturation and clear: force 260 mismatches with ERR_W=8 → err_count=8'hFF; clear with a simultaneous mismatch → err_count=0.
- Async reset mid-count: assert reset between edges while locked → all outputs 0 immediately, state IDLE, reacquires from next valid sample.
